// File: rtl/imem_access_ctrl.sv
// Instruction RAM access controller: arbitrates a single-port synchronous RAM
// between core fetches (alignment/range checked) and an exclusive program loader.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; launches a fetch or hands the RAM to the loader
// RD    | RAM read in flight (or error recorded); response on exit edge
// LOAD  | loader owns the RAM; fetches are held off without response
module imem_access_ctrl #(
    parameter int          INST_ADDR_WIDTH = 9,
    parameter logic [31:0] NOP_INSTR       = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load_mode,
    input  logic                       fetch_req,
    input  logic [31:0]                fetch_pc,
    output logic                       fetch_valid,
    output logic [31:0]                fetch_instr,
    output logic                       fetch_err,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [INST_ADDR_WIDTH-1:0] ld_addr,
    input  logic [31:0]                ld_wdata,
    output logic [INST_ADDR_WIDTH:0]   ld_count,
    output logic                       busy,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [INST_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata
);

    localparam int IAW = INST_ADDR_WIDTH;
    localparam logic [IAW:0] LD_MAX = {1'b1, {IAW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_err_flag;
    logic           r_fetch_valid;
    logic           r_fetch_err;
    logic [31:0]    r_fetch_instr;
    logic [IAW:0]   r_ld_count;

    logic           w_pc_good;
    logic           w_fetch_go;
    logic           w_ld_ready;
    logic           w_ld_wr;

    assign w_pc_good = (fetch_pc[1:0] == 2'b00) && (fetch_pc[31:IAW+2] == '0);

    // The fetch_valid cycle is skipped so the core sees a gap between fetches.
    assign w_fetch_go = (r_state == ST_IDLE) && !load_mode && fetch_req && !r_fetch_valid;

    // Gated by reset_n so the RAM strobes drop the instant reset asserts.
    assign w_ld_ready = reset_n && (r_state == ST_LOAD) && load_mode;
    assign w_ld_wr    = w_ld_ready && ld_valid;

    assign ld_ready  = w_ld_ready;
    assign mem_en    = (reset_n && w_fetch_go && w_pc_good) || w_ld_wr;
    assign mem_we    = w_ld_wr;
    assign mem_addr  = w_ld_wr ? ld_addr : fetch_pc[IAW+1:2];
    assign mem_wdata = ld_wdata;
    assign busy      = (r_state != ST_IDLE);

    assign fetch_valid = r_fetch_valid;
    assign fetch_err   = r_fetch_err;
    assign fetch_instr = r_fetch_instr;
    assign ld_count    = r_ld_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_err_flag    <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_fetch_instr <= NOP_INSTR;
            r_ld_count    <= '0;
        end else begin
            r_fetch_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load_mode) begin
                        r_state    <= ST_LOAD;
                        r_ld_count <= '0;
                    end else if (w_fetch_go) begin
                        r_state    <= ST_RD;
                        r_err_flag <= !w_pc_good;
                    end
                end
                ST_RD: begin
                    r_state       <= ST_IDLE;
                    r_fetch_valid <= 1'b1;
                    r_fetch_err   <= r_err_flag;
                    r_fetch_instr <= r_err_flag ? NOP_INSTR : mem_rdata;
                end
                ST_LOAD: begin
                    if (!load_mode) begin
                        r_state <= ST_IDLE;
                    end else if (ld_valid && (r_ld_count != LD_MAX)) begin
                        r_ld_count <= r_ld_count + (IAW+1)'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed bench for imem_access_ctrl with a behavioural 1-cycle-latency RAM.
module tb_imem_access_ctrl;

    localparam int IAW = 9;
    localparam logic [31:0] NOP = 32'h00000013;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           load_mode;
    logic           fetch_req;
    logic [31:0]    fetch_pc;
    logic           fetch_valid;
    logic [31:0]    fetch_instr;
    logic           fetch_err;
    logic           ld_valid;
    logic           ld_ready;
    logic [IAW-1:0] ld_addr;
    logic [31:0]    ld_wdata;
    logic [IAW:0]   ld_count;
    logic           busy;
    logic           mem_en;
    logic           mem_we;
    logic [IAW-1:0] mem_addr;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem_rdata;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int en_cnt = 0;
    int fv_cnt = 0;

    logic [31:0] ram [0:(1<<IAW)-1];

    imem_access_ctrl #(.INST_ADDR_WIDTH(IAW), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset_n(reset_n), .load_mode(load_mode),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .fetch_err(fetch_err),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_count(ld_count), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        else if (mem_en) mem_rdata <= ram[mem_addr];
        if (mem_we) we_cnt++;
        if (mem_en) en_cnt++;
        if (fetch_valid) fv_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fv(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!fetch_valid && n < 20);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_mode = 1'b0; fetch_req = 1'b1; fetch_pc = 32'h0;
        ld_valid = 1'b0; ld_addr = '0; ld_wdata = '0; mem_rdata = '0;
        repeat (2) tick();
        @(negedge clk);
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", fetch_valid); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", fetch_err); end
        total++; if (fetch_instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", fetch_instr, NOP); end
        total++; if (ld_count !== '0) begin bad++; $display("FAIL reset_ldcount got=%0d exp=0", ld_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if ({mem_en, mem_we, ld_ready} !== 3'b000) begin bad++; $display("FAIL reset_comb got=%b exp=000", {mem_en, mem_we, ld_ready}); end
        fetch_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_fetch();
        int n;
        int fv0;
        fetch_req = 1'b1; fetch_pc = 32'h0;
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0) begin bad++; $display("FAIL fetch_mem got en=%b we=%b a=%h exp 1 0 0", mem_en, mem_we, mem_addr); end
        wait_fv(n);
        fetch_req = 1'b0;
        total++; if (n !== 2) begin bad++; $display("FAIL fetch_latency got=%0d exp=2", n); end
        total++; if (fetch_instr !== 32'h00007033) begin bad++; $display("FAIL fetch_instr got=%h exp=00007033", fetch_instr); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL fetch_err got=%b exp=0", fetch_err); end
        fv0 = fv_cnt;
        tick();
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL fv_pulse got=%b exp=0", fetch_valid); end
        tick();
        total++; if (fetch_instr !== 32'h00007033 || fv_cnt != fv0 + 1) begin bad++; $display("FAIL instr_hold got=%h fv=%0d exp=00007033 fv=%0d", fetch_instr, fv_cnt - fv0, 1); end
    endtask

    task automatic test_load();
        int n;
        int we0;
        int fv0;
        logic [31:0] data [1:3];
        data[1] = 32'h00100093; data[2] = 32'h00200113; data[3] = 32'h00308193;
        load_mode = 1'b1;
        tick();
        fetch_req = 1'b1; fetch_pc = 32'h4;
        we0 = we_cnt; fv0 = fv_cnt;
        @(negedge clk);
        total++; if (ld_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL load_ready got rdy=%b busy=%b exp 1 1", ld_ready, busy); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            ld_valid = 1'b1; ld_addr = IAW'(i); ld_wdata = data[i];
            @(negedge clk);
            total++; if (mem_we !== 1'b1 || mem_en !== 1'b1 || mem_addr !== IAW'(i)) begin bad++; $display("FAIL load_we%0d got we=%b en=%b a=%h", i, mem_we, mem_en, mem_addr); end
            tick();
            ld_valid = 1'b0;
        end
        tick();
        @(negedge clk);
        total++; if (ld_count !== 10'd3) begin bad++; $display("FAIL load_count got=%0d exp=3", ld_count); end
        total++; if (we_cnt - we0 != 3) begin bad++; $display("FAIL load_we_pulses got=%0d exp=3", we_cnt - we0); end
        total++; if (fv_cnt != fv0) begin bad++; $display("FAIL load_fetch_held got=%0d exp=0", fv_cnt - fv0); end
        tick();
        load_mode = 1'b0; ld_valid = 1'b1; ld_addr = 9'd7; ld_wdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (ld_ready !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL load_exit got rdy=%b we=%b exp 0 0", ld_ready, mem_we); end
        tick();
        ld_valid = 1'b0;
        wait_fv(n);
        fetch_req = 1'b0;
        total++; if (n !== 2 || fetch_instr !== 32'h00100093) begin bad++; $display("FAIL load_then_fetch got n=%0d instr=%h exp 2 00100093", n, fetch_instr); end
        total++; if (ld_count !== 10'd3) begin bad++; $display("FAIL load_count_hold got=%0d exp=3", ld_count); end
        tick();
    endtask

    task automatic test_errors();
        int n;
        int en0;
        logic [31:0] pcs [2];
        pcs[0] = 32'h6; pcs[1] = 32'h800;
        for (int k = 0; k < 2; k++) begin
            en0 = en_cnt;
            fetch_req = 1'b1; fetch_pc = pcs[k];
            wait_fv(n);
            fetch_req = 1'b0;
            total++; if (n !== 2 || fetch_err !== 1'b1) begin bad++; $display("FAIL err_pc%h got n=%0d err=%b exp 2 1", pcs[k], n, fetch_err); end
            total++; if (fetch_instr !== NOP) begin bad++; $display("FAIL err_instr_pc%h got=%h exp=%h", pcs[k], fetch_instr, NOP); end
            total++; if (en_cnt != en0) begin bad++; $display("FAIL err_mem_en_pc%h got=%0d exp=0", pcs[k], en_cnt - en0); end
            tick();
        end
    endtask

    task automatic test_load_during_rd();
        fetch_req = 1'b1; fetch_pc = 32'h8;
        tick();
        load_mode = 1'b1;
        @(negedge clk);
        total++; if (ld_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rd_load_ready got rdy=%b busy=%b exp 0 1", ld_ready, busy); end
        tick();
        fetch_req = 1'b0;
        total++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h00200113 || fetch_err !== 1'b0) begin bad++; $display("FAIL rd_load_fetch got fv=%b instr=%h err=%b exp 1 00200113 0", fetch_valid, fetch_instr, fetch_err); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL rd_load_ready_idle got=%b exp=0", ld_ready); end
        tick();
        total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL rd_load_enter got=%b exp=1", ld_ready); end
        load_mode = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_during_write();
        load_mode = 1'b1;
        tick();
        ld_valid = 1'b1; ld_addr = 9'd5; ld_wdata = 32'hAAAA5555;
        tick();
        ld_addr = 9'd6;
        @(negedge clk);
        total++; if (mem_we !== 1'b1 || ld_count !== 10'd1) begin bad++; $display("FAIL rst_wr_pre got we=%b cnt=%0d exp 1 1", mem_we, ld_count); end
        #1 reset_n = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0 || mem_en !== 1'b0 || ld_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_comb got we=%b en=%b rdy=%b exp 000", mem_we, mem_en, ld_ready); end
        total++; if (ld_count !== '0 || fetch_instr !== NOP) begin bad++; $display("FAIL rst_wr_regs got cnt=%0d instr=%h exp 0 %h", ld_count, fetch_instr, NOP); end
        ld_valid = 1'b0; load_mode = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        int fv0;
        logic [31:0] exp [3];
        exp[0] = 32'h00007033; exp[1] = 32'h00100093; exp[2] = 32'h00200113;
        for (int i = 0; i < 3; i++) ram[i] = exp[i];
        fv0 = fv_cnt;
        fetch_req = 1'b1; fetch_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            wait_fv(n);
            total++; if (n !== (i == 0 ? 2 : 3)) begin bad++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, n, (i == 0 ? 2 : 3)); end
            total++; if (fetch_instr !== exp[i]) begin bad++; $display("FAIL b2b_instr%0d got=%h exp=%h", i, fetch_instr, exp[i]); end
            if (i < 2) fetch_pc = 32'((i + 1) * 4);
            else fetch_req = 1'b0;
            @(negedge clk);
            total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL b2b_gap_en%0d got=%b exp=0", i, mem_en); end
        end
        repeat (4) tick();
        total++; if (fv_cnt - fv0 != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", fv_cnt - fv0); end
    endtask

    initial begin
        for (int i = 0; i < (1 << IAW); i++) ram[i] = 32'h0;
        ram[0] = 32'h00007033;
        test_reset();
        test_basic_fetch();
        test_load();
        test_errors();
        test_load_during_rd();
        test_reset_during_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
